// File: rtl/botao_pedestre_pkg.sv
// ---------------------------------------------------------------------------
// botao_pedestre_pkg
//   Shared definitions for the pedestrian push-button conditioner and the
//   traffic-light controller bench that reuses them.
//   - state_t : request FSM encoding (IDLE=0, REQ=1, LOCKOUT=2; 3 is illegal)
//   - DEF_*   : default parameter values for the conditioner
// ---------------------------------------------------------------------------
package botao_pedestre_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LOCKOUT_CYCLES  = 32;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/botao_pedestre_debounce.sv
// ---------------------------------------------------------------------------
// botao_pedestre_debounce
//   Synchronises an asynchronous, bouncy level into the clk domain and only
//   lets it change the output after DEBOUNCE_CYCLES consecutive samples that
//   disagree with the current output.
// Parameters
//   SYNC_STAGES      flip-flops in the synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing samples needed to flip dout (>= 1)
// Ports
//   clk   in   single clock, all state on posedge
//   rst   in   asynchronous active-low reset
//   din   in   raw asynchronous level
//   dout  out  debounced, registered level
// ---------------------------------------------------------------------------
module botao_pedestre_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;

  // Plain shift-register synchroniser; the oldest bit is the usable sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter measures the run length of samples that disagree with the
  // current output; any agreeing sample restarts the run, so a glitch
  // shorter than DEBOUNCE_CYCLES samples never reaches dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (w_s == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_db  <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign dout = r_db;

endmodule

// File: rtl/botao_pedestre.sv
// ---------------------------------------------------------------------------
// botao_pedestre
//   Conditions the raw pedestrian push-button into the held request level
//   `bt` for the traffic-light controller:
//   synchronise -> debounce -> rising-edge detect -> request latch that is
//   held until the controller acknowledges it.
// Build option
//   BOTAO_LOCKOUT_EN : when defined, an acknowledged request is followed by a
//                      LOCKOUT_CYCLES blanking window in which presses are
//                      ignored. When undefined there is no LOCKOUT state and
//                      no timer; REQ returns straight to IDLE on ack.
// Parameters
//   SYNC_STAGES, DEBOUNCE_CYCLES, LOCKOUT_CYCLES, CNT_W
// Ports
//   clk        in   single clock, all state on posedge
//   rst        in   asynchronous active-low reset (0 = reset)
//   btn_raw    in   mechanical button, asynchronous, bouncy, 1 = pressed
//   ack        in   one-cycle pulse from the controller: request served
//   bt         out  registered request level to the controller
//   btn_db     out  debounced button level (registered)
//   req_count  out  accepted requests, saturating at 2^CNT_W-1
//   dbg_state  out  current FSM state encoding (state_t)
// Handshake
//   bt is a level: it rises when a press is accepted and stays high until the
//   controller returns a single-cycle ack strobe. ack outside REQ is ignored;
//   there is no queueing, so a press while bt=1 is dropped.
// ---------------------------------------------------------------------------
module botao_pedestre
  import botao_pedestre_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             ack,
  output logic             bt,
  output logic             btn_db,
  output logic [CNT_W-1:0] req_count,
  output logic [1:0]       dbg_state
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lock
    $error("LOCKOUT_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_db;
  logic             r_db_q;
  logic             w_press;
  state_t           r_state;
  logic             r_bt;
  logic [CNT_W-1:0] r_count;

`ifdef BOTAO_LOCKOUT_EN
  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  logic [TMR_W-1:0] r_timer;
`endif

  botao_pedestre_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_raw),
    .dout (w_db)
  );

  // Rising edge of the debounced level only; releases produce nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_q <= 1'b0;
    end else begin
      r_db_q <= w_db;
    end
  end

  assign w_press = w_db & ~r_db_q;

  // Request FSM. bt is registered alongside the state so it always equals
  // (state == REQ) without a decode after the flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_bt    <= 1'b0;
      r_count <= '0;
`ifdef BOTAO_LOCKOUT_EN
      r_timer <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_bt <= 1'b0;
          if (w_press) begin
            r_state <= REQ;
            r_bt    <= 1'b1;
            if (r_count != CNT_MAX) begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        REQ: begin
          r_bt <= 1'b1;
          // ack wins over a same-cycle press; that press is simply lost.
          if (ack) begin
            r_bt <= 1'b0;
`ifdef BOTAO_LOCKOUT_EN
            r_state <= LOCKOUT;
            r_timer <= TMR_LOAD;
`else
            r_state <= IDLE;
`endif
          end
        end
`ifdef BOTAO_LOCKOUT_EN
        LOCKOUT: begin
          // Presses and acks are ignored here; a button still held when the
          // window closes needs a fresh rising edge to request again.
          r_bt <= 1'b0;
          if (r_timer == '0) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
`endif
        default: begin
          // Illegal (or compiled-out) encoding: recover to IDLE.
          r_state <= IDLE;
          r_bt    <= 1'b0;
        end
      endcase
    end
  end

  assign bt        = r_bt;
  assign btn_db    = w_db;
  assign req_count = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_botao_pedestre.sv
// ---------------------------------------------------------------------------
// tb_botao_pedestre
//   Bench for botao_pedestre at default parameters. Expectations follow the
//   BOTAO_LOCKOUT_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_botao_pedestre;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LOCK = 32;
  localparam int CW   = 8;
  localparam logic [CW-1:0] CNT_MAX = 8'd255;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

`ifdef BOTAO_LOCKOUT_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          btn_raw;
  logic          ack;
  logic          bt;
  logic          btn_db;
  logic [CW-1:0] req_count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  botao_pedestre #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK),
    .CNT_W           (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .ack       (ack),
    .bt        (bt),
    .btn_db    (btn_db),
    .req_count (req_count),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sync is a plain delay line; the debounced level flips when the last DEB
  // synchronised samples all disagree with it; a request is a flag plus a
  // remaining-blanking count.
  bit   sq[$];
  bit   hist[$];
  bit   m_db, m_db_q, m_pend;
  int   m_lock;
  logic [CW-1:0] m_cnt;
  logic bt_seen;

  task automatic model_clear();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
    hist.delete();
    m_db = 0; m_db_q = 0; m_pend = 0; m_lock = 0; m_cnt = '0;
    exp_q.delete();
    bt_seen = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    bit s, pr, flip, new_db;
    if (!rst) begin
      model_clear();
    end else begin
      pr = m_db & ~m_db_q;
      s  = sq.pop_front();
      sq.push_back(btn_raw);
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      new_db = m_db;
      if (hist.size() == DEB) begin
        flip = 1'b1;
        foreach (hist[i]) if (hist[i] == m_db) flip = 1'b0;
        if (flip) new_db = ~m_db;
      end
      if (m_pend) begin
        if (ack) begin
          m_pend = 1'b0;
          if (LOCK_ON) m_lock = LOCK;
        end
      end else if (m_lock > 0) begin
        m_lock--;
      end else if (pr) begin
        m_pend = 1'b1;
        if (m_cnt != CNT_MAX) m_cnt = m_cnt + 8'd1;
        exp_q.push_back(m_cnt);
      end
      m_db_q = m_db;
      m_db   = new_db;
    end
  end

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("model_bt", bt, m_pend);
      check("model_db", btn_db, m_db);
      check("model_cnt", req_count, m_cnt);
      check("model_state", dbg_state, m_pend ? S_REQ : (m_lock > 0 ? S_LOCK : S_IDLE));
      if (bt === 1'b1 && bt_seen !== 1'b1) begin
        if (exp_q.size() == 0) check("req_unexpected", 1, 0);
        else check("req_rise_cnt", req_count, exp_q.pop_front());
      end
      bt_seen = bt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic wait_bt(input logic v, input int max, input string name);
    int k = 0;
    while (bt !== v && k < max) begin step(1); k++; end
    check(name, bt, v);
  endtask

  task automatic wait_db(input logic v, input int max, input string name);
    int k = 0;
    while (btn_db !== v && k < max) begin step(1); k++; end
    check(name, btn_db, v);
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
  endtask

  typedef struct {
    int hi;
    bit req;
  } pulse_vec_t;

  pulse_vec_t pv[6];

  // ---------------- test sequence ----------------
  initial begin
    int exp_cnt;
    pv[0] = '{1, 1'b0};
    pv[1] = '{8, 1'b0};
    pv[2] = '{15, 1'b0};
    pv[3] = '{16, 1'b1};
    pv[4] = '{17, 1'b0};
    pv[5] = '{25, 1'b1};
    // entry 4 holds 17: long enough, so it requests too
    pv[4].req = 1'b1;

    model_clear();
    rst = 1'b0; btn_raw = 1'b1; ack = 1'b0;

    // 1: reset holds outputs low even with the button pressed
    step(3);
    for (int i = 0; i < 4; i++) begin
      check("rst_bt", bt, 0);
      check("rst_db", btn_db, 0);
      check("rst_cnt", req_count, 0);
      check("rst_state", dbg_state, S_IDLE);
      step(1);
    end
    btn_raw = 1'b0;
    rst = 1'b1;
    step(30);
    check("idle_bt", bt, 0);

    // 2: clean press latency, then ack
    btn_raw = 1'b1;
    step(17);
    check("press_db_e17", btn_db, 0);
    step(1);
    check("press_db_e18", btn_db, 1);
    check("press_bt_e18", bt, 0);
    step(1);
    check("press_bt_e19", bt, 1);
    check("press_cnt", req_count, 1);
    check("press_state", dbg_state, S_REQ);
    pulse_ack();
    check("ack_bt", bt, 0);
    check("ack_state", dbg_state, LOCK_ON ? S_LOCK : S_IDLE);
    btn_raw = 1'b0;
    step(60);

    // 3: bounce for 100 cycles never gets through
    for (int t = 0; t < 20; t++) begin
      btn_raw = ~btn_raw;
      step(5);
      check("bounce_db", btn_db, 0);
      check("bounce_bt", bt, 0);
    end
    btn_raw = 1'b1;
    step(19);
    check("bounce_then_bt", bt, 1);
    check("bounce_then_cnt", req_count, 2);
    step(30);
    check("bounce_once_cnt", req_count, 2);

    // 4: press and ack on the same edge while in REQ
    btn_raw = 1'b0;
    wait_db(0, 40, "rel_db_t4");
    btn_raw = 1'b1;
    step(18);
    check("same_db", btn_db, 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("same_bt", bt, 0);
    check("same_cnt", req_count, 2);
    btn_raw = 1'b0;
    step(60);
    btn_raw = 1'b1;
    step(19);
    check("again_bt", bt, 1);
    check("again_cnt", req_count, 3);

    // 5: press landing one cycle after ack
    btn_raw = 1'b0;
    wait_db(0, 40, "rel_db_t5");
    btn_raw = 1'b1;
    step(17);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("lock_ack_bt", bt, 0);
    check("lock_db_up", btn_db, 1);
    step(1);
    exp_cnt = LOCK_ON ? 3 : 4;
    check("lock_press_bt", bt, !LOCK_ON);
    check("lock_press_cnt", req_count, exp_cnt);
    step(45);
    check("lock_held_bt", bt, !LOCK_ON);
    check("lock_held_cnt", req_count, exp_cnt);
    if (!LOCK_ON) pulse_ack();
    btn_raw = 1'b0;
    step(60);

    // table: pulse width vs. request
    foreach (pv[i]) begin
      btn_raw = 1'b1;
      step(pv[i].hi);
      btn_raw = 1'b0;
      step(30);
      if (pv[i].req) exp_cnt++;
      check($sformatf("pulse%0d_bt", pv[i].hi), bt, pv[i].req);
      check($sformatf("pulse%0d_cnt", pv[i].hi), req_count, exp_cnt);
      if (pv[i].req) pulse_ack();
      step(60);
    end

    // random stimulus against the model
    for (int seg = 0; seg < 150; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) begin
        ack = ($urandom_range(0, 7) == 0);
        step(1);
      end
    end
    ack = 1'b0;
    btn_raw = 1'b0;
    step(60);

    // 6: saturation, then asynchronous reset while requesting
    rst = 1'b0;
    step(2);
    check("rst2_cnt", req_count, 0);
    rst = 1'b1;
    step(2);
    for (int i = 0; i < 260; i++) begin
      btn_raw = 1'b1;
      wait_bt(1, 30, "sat_req");
      btn_raw = 1'b0;
      pulse_ack();
      step(40);
    end
    check("sat_cnt", req_count, CNT_MAX);
    btn_raw = 1'b1;
    wait_bt(1, 30, "sat_last_req");
    check("sat_hold_cnt", req_count, CNT_MAX);
    #2;
    rst = 1'b0;
    #1;
    check("async_bt", bt, 0);
    check("async_state", dbg_state, S_IDLE);
    check("async_cnt", req_count, 0);
    check("async_db", btn_db, 0);
    step(2);
    rst = 1'b1;
    btn_raw = 1'b0;
    step(5);

    report();
    $finish;
  end

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $fatal(1, "watchdog");
  end

endmodule
